// File: rtl/fifo_wptr_ctrl_pkg.sv
// Shared widths and defaults for the write-side pointer controller of the
// async CDC FIFO. The read-side controller sees the same defines.
`ifndef FIFO_PTR_PARAMETERS_DEFINED
`define FIFO_PTR_PARAMETERS_DEFINED
`define WPTR_WIDTH   8
`define FIFO_DEPTH   128
`define AFULL_THRESH 120
`endif

package fifo_wptr_ctrl_pkg;

  // Pointer width carries one extra wrap bit above the memory address.
  localparam int PW_DEFAULT    = `WPTR_WIDTH;
  localparam int AFULL_DEFAULT = `AFULL_THRESH;

  // Registered status flags, kept together so they clear and load as one.
  typedef struct packed {
    logic full;
    logic afull;
    logic ovf;
  } wflags_t;

endpackage

// File: rtl/fifo_wptr_ctrl_if.sv
// Producer-facing bundle of the write-side controller: requests and the
// synchronised read pointer go in, memory strobe and status come out.
interface fifo_wptr_ctrl_if
  import fifo_wptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = PW_DEFAULT - 1
);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  winc;
  logic [PW-1:0]         wq2_rptr;
  logic                  wovf_clr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PW-1:0]         wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [PW-1:0]         wlevel;
  logic                  wovf;

  // Producer side: drives requests, observes memory strobe and status.
  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  // Controller side.
  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/bin2gray.sv
// Parameterised binary-to-Gray encoder shared across the FIFO pointer logic.
module bin2gray #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/fifo_wptr_ctrl_gray2bin.sv
// Gray-to-binary pointer decode: each binary bit is the XOR of all Gray bits
// at or above it. Purely combinational; also used by the read-side controller.
module gray2bin_ptr #(
  parameter int PW = 8
) (
  input  logic [PW-1:0] gray,
  output logic [PW-1:0] bin
);
  logic acc_s;

  // Running XOR from the MSB downwards forms the prefix parity.
  always_comb begin
    acc_s = 1'b0;
    bin   = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc_s  = acc_s ^ gray[i];
      bin[i] = acc_s;
    end
  end
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain half of the async FIFO. Advances the binary write pointer on
// accepted writes, publishes it in registered Gray form for the read domain,
// and derives full / almost-full / level / sticky overflow from the
// synchronised Gray read pointer. Flags lag real reads, so they err towards full.
module fifo_wptr_ctrl
  import fifo_wptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = PW_DEFAULT - 1,
  parameter int AFULL_THRESH = AFULL_DEFAULT
) (
  input logic              wclk,
  input logic              wrst_n,
  fifo_wptr_ctrl_if.slave  bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] wlevel_r;
  wflags_t       flags_r;

  logic          wen_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next_s;
  logic [PW-1:0] full_pat_s;
  wflags_t       flags_next_s;

  bin2gray #(.W(PW)) u_bin2gray (
    .bin  (wbin_next_s),
    .gray (wgray_next_s)
  );

  gray2bin_ptr #(.PW(PW)) u_gray2bin (
    .gray (bus.wq2_rptr),
    .bin  (rbin_s)
  );

  // Write acceptance, pointer advance, occupancy and next flag values.
  always_comb begin
    wen_s        = bus.winc & ~flags_r.full;
    wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, wen_s};
    level_next_s = wbin_next_s - rbin_s;
    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray form that is the top two bits inverted, the rest equal.
    full_pat_s   = {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]};
    flags_next_s.full  = (wgray_next_s == full_pat_s);
    flags_next_s.afull = (level_next_s >= AFULL_LVL);
    // A rejected write takes priority over a simultaneous clear.
    if (bus.winc & flags_r.full) begin
      flags_next_s.ovf = 1'b1;
    end else if (bus.wovf_clr) begin
      flags_next_s.ovf = 1'b0;
    end else begin
      flags_next_s.ovf = flags_r.ovf;
    end
  end

  // Pointer, level and flag registers; Gray pointer leaves the block only from a flop.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r   <= '0;
      wptr_r   <= '0;
      wlevel_r <= '0;
      flags_r  <= '0;
    end else begin
      wbin_r   <= wbin_next_s;
      wptr_r   <= wgray_next_s;
      wlevel_r <= level_next_s;
      flags_r  <= flags_next_s;
    end
  end

  assign bus.wen          = wen_s;
  assign bus.waddr        = wbin_r[ADDR_WIDTH-1:0];
  assign bus.wptr         = wptr_r;
  assign bus.wlevel       = wlevel_r;
  assign bus.wfull        = flags_r.full;
  assign bus.walmost_full = flags_r.afull;
  assign bus.wovf         = flags_r.ovf;
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Scoreboard bench for the write-side FIFO pointer controller.
module tb_fifo_wptr_ctrl;
  localparam int AW = 7;
  localparam int PW = 8;

  typedef struct packed {
    logic [PW-1:0] wptr;
    logic          full;
    logic          afull;
    logic [PW-1:0] level;
    logic          ovf;
  } exp_t;

  logic wclk;
  logic wrst_n;

  fifo_wptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(120)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_vec;
  int n_err;
  exp_t sb_q[$];

  // Bench model state
  logic [PW-1:0] m_wbin;
  logic          m_full;
  logic          m_ovf;
  logic [PW-1:0] m_rbin;
  logic          saw_wptr_wrap;
  logic          saw_waddr_wrap;
  logic          in_wrap;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    to_gray = b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic void model_reset();
    m_wbin = '0; m_full = 1'b0; m_ovf = 1'b0; m_rbin = '0;
  endfunction

  // One clock: drive inputs away from the edge, check combinational outputs,
  // push the expected registered state, then compare it after the edge.
  task automatic step(input logic inc, input logic [PW-1:0] rg, input logic clr);
    logic          en;
    logic [PW-1:0] lvl;
    logic [PW-1:0] prev_wptr;
    logic [AW-1:0] prev_addr;
    exp_t e, got;
    bus.winc = inc; bus.wq2_rptr = rg; bus.wovf_clr = clr;
    #1;
    en = inc & ~m_full;
    check("wen", bus.wen, en);
    check("waddr", bus.waddr, m_wbin[AW-1:0]);
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_wbin = m_wbin + (en ? 8'd1 : 8'd0);
    m_rbin = to_bin(rg);
    lvl    = m_wbin - m_rbin;
    m_full = (to_gray(m_wbin) == {~rg[PW-1:PW-2], rg[PW-3:0]});
    e.wptr = to_gray(m_wbin); e.full = m_full; e.afull = (lvl >= 8'd120);
    e.level = lvl; e.ovf = m_ovf;
    sb_q.push_back(e);
    prev_wptr = bus.wptr;
    prev_addr = bus.waddr;
    @(posedge wclk);
    #1;
    e = sb_q.pop_front();
    got = '{bus.wptr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
    check("wptr", got.wptr, e.wptr);
    check("wfull", got.full, e.full);
    check("walmost_full", got.afull, e.afull);
    check("wlevel", got.level, e.level);
    check("wovf", got.ovf, e.ovf);
    check("level_legal", {31'd0, bus.wlevel <= 8'd128}, 32'd1);
    if (bus.wptr != prev_wptr)
      check("wptr_hamming", $countones(bus.wptr ^ prev_wptr), 32'd1);
    if (in_wrap && prev_wptr == 8'h80 && bus.wptr == 8'h00) saw_wptr_wrap = 1'b1;
    if (in_wrap && prev_addr == 7'd127 && bus.waddr == 7'd0) saw_waddr_wrap = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    saw_wptr_wrap = 1'b0; saw_waddr_wrap = 1'b0; in_wrap = 1'b0;
    model_reset();
    bus.winc = 1'b0; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;
    wrst_n = 1'b0;
    #3;
    check("rst_wptr", bus.wptr, 0);
    check("rst_wlevel", bus.wlevel, 0);
    check("rst_flags", {bus.wfull, bus.walmost_full, bus.wovf, bus.wen}, 0);
    @(negedge wclk); wrst_n = 1'b1;
    @(posedge wclk); #1;

    // A few writes, then reset mid-cycle without a clock edge
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b0);
    bus.winc = 1'b0;
    #1 wrst_n = 1'b0;
    #1;
    check("async_rst_wptr", bus.wptr, 0);
    check("async_rst_wlevel", bus.wlevel, 0);
    check("async_rst_waddr", bus.waddr, 0);
    check("async_rst_flags", {bus.wfull, bus.walmost_full, bus.wovf}, 0);
    model_reset();
    @(negedge wclk); wrst_n = 1'b1;
    @(posedge wclk); #1;

    // Fill from empty with the read pointer parked at 0
    for (int i = 1; i <= 128; i++) begin
      step(1'b1, 8'h00, 1'b0);
      if (i == 119) check("fill_afull_119", bus.walmost_full, 0);
      if (i == 120) begin
        check("fill_afull_120", bus.walmost_full, 1);
        check("fill_level_120", bus.wlevel, 120);
      end
      if (i == 127) check("fill_full_127", bus.wfull, 0);
    end
    check("full_flag", bus.wfull, 1);
    check("full_wptr", bus.wptr, 8'hC0);
    check("full_level", bus.wlevel, 128);
    check("full_waddr", bus.waddr, 0);

    // Overflow attempts, then clear
    step(1'b1, 8'h00, 1'b0);
    check("ovf_set", bus.wovf, 1);
    step(1'b1, 8'h00, 1'b0);
    check("ovf_wptr_hold", bus.wptr, 8'hC0);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", bus.wovf, 0);

    // Drain via read pointer advance
    step(1'b0, 8'h0C, 1'b0);
    check("drain8_full", bus.wfull, 0);
    check("drain8_level", bus.wlevel, 120);
    check("drain8_afull", bus.walmost_full, 1);
    step(1'b0, 8'h0D, 1'b0);
    check("drain9_afull", bus.walmost_full, 0);
    check("drain9_level", bus.wlevel, 119);

    // Streaming wrap with the reader trailing by 3
    step(1'b0, to_gray(m_wbin - 8'd3), 1'b0);
    in_wrap = 1'b1;
    for (int i = 0; i < 300; i++) step(1'b1, to_gray(m_wbin - 8'd3), 1'b0);
    in_wrap = 1'b0;
    check("wrap_wptr_seen", saw_wptr_wrap, 1);
    check("wrap_waddr_seen", saw_waddr_wrap, 1);

    // Concurrent write and read advance at level 64
    while (m_wbin - m_rbin < 8'd64) step(1'b1, to_gray(m_rbin), 1'b0);
    check("conc_pre_level", bus.wlevel, 64);
    begin
      logic [PW-1:0] exp_wptr;
      exp_wptr = to_gray(m_wbin + 8'd1);
      step(1'b1, to_gray(m_rbin + 8'd1), 1'b0);
      check("conc_level", bus.wlevel, 64);
      check("conc_wptr", bus.wptr, exp_wptr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
